// File: rtl/rgmii_tx_framer.sv
// Ethernet transmit framer: preamble/SFD, payload, zero pad, CRC-32 FCS and IFG,
// with the GMII byte stream folded onto 4-bit RGMII DDR pins.
module rgmii_tx_framer #(
  parameter int IFG_BYTES   = 12,
  parameter int MIN_PAYLOAD = 60
) (
  input  logic       tx_clk,
  input  logic       rst_n,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  input  logic       s_tuser,
  output logic       s_tready,
  output logic       rgmii_txc,
  output logic [3:0] rgmii_txd,
  output logic       rgmii_tx_ctl,
  output logic       frame_done,
  output logic       underflow
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG} state_t;

  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
  localparam logic [16:0] MIN_LEN  = 17'(MIN_PAYLOAD);

  state_t      state, state_next;
  logic [2:0]  pre_cnt, pre_cnt_next;
  logic [15:0] byte_cnt, byte_cnt_next;
  logic [7:0]  ifg_cnt, ifg_cnt_next;
  logic [1:0]  fcs_cnt, fcs_cnt_next;
  logic [31:0] crc, crc_next;
  logic        user_flag, user_next;
  logic [7:0]  tx_byte, byte_next;
  logic        tx_en, en_next;
  logic        tx_er, er_next;
  logic        done_next, uflow_next;
  logic [16:0] cnt_plus1;
  logic [15:0] cnt_inc;
  logic [31:0] fcs_word;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign cnt_plus1 = {1'b0, byte_cnt} + 17'd1;
  assign cnt_inc   = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
  // A frame flagged bad by s_tuser skips the final XOR so the receiver's FCS check fails.
  assign fcs_word  = user_flag ? crc : ~crc;
  assign s_tready  = (state == DATA);
  assign rgmii_txc = tx_clk;

  always_comb begin
    state_next    = state;
    pre_cnt_next  = pre_cnt;
    byte_cnt_next = byte_cnt;
    ifg_cnt_next  = ifg_cnt;
    fcs_cnt_next  = fcs_cnt;
    crc_next      = crc;
    user_next     = user_flag;
    byte_next     = 8'h00;
    en_next       = 1'b0;
    er_next       = 1'b0;
    done_next     = 1'b0;
    uflow_next    = 1'b0;
    case (state)
      IDLE: begin
        if (s_tvalid) begin
          state_next   = PREAMBLE;
          pre_cnt_next = 3'd0;
        end
      end
      PREAMBLE: begin
        byte_next    = 8'h55;
        en_next      = 1'b1;
        pre_cnt_next = pre_cnt + 3'd1;
        if (pre_cnt == 3'd6) begin
          state_next   = SFD;
          pre_cnt_next = 3'd0;
        end
      end
      SFD: begin
        byte_next     = 8'hD5;
        en_next       = 1'b1;
        crc_next      = 32'hFFFFFFFF;
        byte_cnt_next = 16'd0;
        fcs_cnt_next  = 2'd0;
        user_next     = 1'b0;
        state_next    = DATA;
      end
      DATA: begin
        en_next = 1'b1;
        if (s_tvalid) begin
          byte_next     = s_tdata;
          crc_next      = crc_step(crc, s_tdata);
          byte_cnt_next = cnt_inc;
          if (s_tlast) begin
            user_next  = s_tuser;
            state_next = (cnt_plus1 < MIN_LEN) ? PAD : FCS;
          end
        end else begin
          // Underrun: poison the frame with an error byte and abandon the FCS.
          er_next      = 1'b1;
          uflow_next   = 1'b1;
          state_next   = IFG;
          ifg_cnt_next = 8'd0;
        end
      end
      PAD: begin
        en_next       = 1'b1;
        crc_next      = crc_step(crc, 8'h00);
        byte_cnt_next = cnt_inc;
        if (cnt_plus1 >= MIN_LEN) state_next = FCS;
      end
      FCS: begin
        en_next      = 1'b1;
        byte_next    = fcs_word[{fcs_cnt, 3'b000} +: 8];
        fcs_cnt_next = fcs_cnt + 2'd1;
        if (fcs_cnt == 2'd3) begin
          done_next    = 1'b1;
          state_next   = IFG;
          ifg_cnt_next = 8'd0;
        end
      end
      IFG: begin
        if (ifg_cnt == IFG_LAST) begin
          state_next   = IDLE;
          ifg_cnt_next = 8'd0;
        end else begin
          ifg_cnt_next = ifg_cnt + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pre_cnt    <= 3'd0;
      byte_cnt   <= 16'd0;
      ifg_cnt    <= 8'd0;
      fcs_cnt    <= 2'd0;
      crc        <= 32'hFFFFFFFF;
      user_flag  <= 1'b0;
      tx_byte    <= 8'h00;
      tx_en      <= 1'b0;
      tx_er      <= 1'b0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state      <= state_next;
      pre_cnt    <= pre_cnt_next;
      byte_cnt   <= byte_cnt_next;
      ifg_cnt    <= ifg_cnt_next;
      fcs_cnt    <= fcs_cnt_next;
      crc        <= crc_next;
      user_flag  <= user_next;
      tx_byte    <= byte_next;
      tx_en      <= en_next;
      tx_er      <= er_next;
      frame_done <= done_next;
      underflow  <= uflow_next;
    end
  end

  // DDR output: the high half is staged on the rising edge so both nibbles of a
  // wire cycle come from the same byte.
  logic [3:0] txd_rise, txd_fall_d, txd_fall;
  logic       ctl_rise, ctl_fall_d, ctl_fall;

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      txd_rise   <= 4'h0;
      ctl_rise   <= 1'b0;
      txd_fall_d <= 4'h0;
      ctl_fall_d <= 1'b0;
    end else begin
      txd_rise   <= tx_byte[3:0];
      ctl_rise   <= tx_en;
      txd_fall_d <= tx_byte[7:4];
      ctl_fall_d <= tx_en ^ tx_er;
    end
  end

  always_ff @(negedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      txd_fall <= 4'h0;
      ctl_fall <= 1'b0;
    end else begin
      txd_fall <= txd_fall_d;
      ctl_fall <= ctl_fall_d;
    end
  end

  assign rgmii_txd    = tx_clk ? txd_rise : txd_fall;
  assign rgmii_tx_ctl = tx_clk ? ctl_rise : ctl_fall;

endmodule
